// File: rtl/hs_reg_slice_pkg.sv
// Shared constants and FULL-mode state encoding for the valid/ready register slice.
package hs_pkg;

    localparam int unsigned MODE_BYPASS = 0;
    localparam int unsigned MODE_FWD    = 1;
    localparam int unsigned MODE_BWD    = 2;
    localparam int unsigned MODE_FULL   = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } slice_state_e;

endpackage

// File: rtl/hs_reg_slice_if.sv
// Valid/ready streaming link; master drives valid/data, slave drives ready.
interface hs_reg_slice_if #(
    parameter int unsigned WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/hs_reg_slice_stage.sv
// One valid/ready slice; MODE picks forward register, skid buffer or 2-entry full slice.
module hs_reg_slice_stage
    import hs_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MODE  = MODE_FULL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             occ_o
);

    if (MODE == MODE_FWD) begin : g_fwd
        logic             valid_q, valid_d;
        logic [WIDTH-1:0] data_q, data_d;

        assign in_ready_o = out_ready_i | ~valid_q;

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (in_ready_o) begin
                valid_d = in_valid_i;
                if (in_valid_i) data_d = in_data_i;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign out_valid_o = valid_q;
        assign out_data_o  = data_q;
        assign occ_o       = valid_q;

    end else if (MODE == MODE_BWD) begin : g_bwd
        logic             skid_full_q, skid_full_d;
        logic             rdy_q;
        logic [WIDTH-1:0] skid_data_q, skid_data_d;
        logic             capture;

        // rdy_q is low in reset, which also keeps reset-time beats from passing through
        assign capture = ~skid_full_q & in_valid_i & rdy_q & ~out_ready_i;

        always_comb begin
            skid_full_d = skid_full_q;
            skid_data_d = skid_data_q;
            if (skid_full_q) begin
                if (out_ready_i) skid_full_d = 1'b0;
            end else if (capture) begin
                skid_full_d = 1'b1;
                skid_data_d = in_data_i;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                skid_full_q <= 1'b0;
                skid_data_q <= '0;
                rdy_q       <= 1'b0;
            end else begin
                skid_full_q <= skid_full_d;
                skid_data_q <= skid_data_d;
                rdy_q       <= ~skid_full_d;
            end
        end

        assign in_ready_o  = rdy_q;
        assign out_valid_o = skid_full_q | (in_valid_i & rdy_q);
        assign out_data_o  = skid_full_q ? skid_data_q : in_data_i;
        assign occ_o       = skid_full_q;

    end else if (MODE == MODE_FULL) begin : g_full
        slice_state_e     state_q, state_d;
        logic [WIDTH-1:0] out_q, out_d;
        logic [WIDTH-1:0] skid_q, skid_d;
        logic             rdy_q;
        logic             push, pop;

        assign push = in_valid_i & rdy_q;
        assign pop  = (state_q != EMPTY) & out_ready_i;

        always_comb begin
            state_d = state_q;
            out_d   = out_q;
            skid_d  = skid_q;
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        out_d   = in_data_i;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_d = TWO;
                        skid_d  = in_data_i;
                    end else if (!push && pop) begin
                        state_d = EMPTY;
                    end else if (push && pop) begin
                        out_d = in_data_i;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d = ONE;
                        out_d   = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= EMPTY;
                out_q   <= '0;
                skid_q  <= '0;
                rdy_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                out_q   <= out_d;
                skid_q  <= skid_d;
                rdy_q   <= (state_d != TWO);
            end
        end

        assign in_ready_o  = rdy_q;
        assign out_valid_o = (state_q != EMPTY);
        assign out_data_o  = out_q;
        assign occ_o       = (state_q != EMPTY);

    end else begin : g_bad
        $error("hs_reg_slice_stage: unsupported MODE %0d", MODE);
    end

endmodule

// File: rtl/hs_reg_slice.sv
// Chain of STAGES valid/ready slices between an upstream and a downstream link.
module hs_reg_slice
    import hs_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 1,
    parameter int unsigned MODE   = MODE_FULL
) (
    input  logic          clk,
    input  logic          rst,
    hs_reg_slice_if.slave  m_if,
    hs_reg_slice_if.master s_if,
    output logic          busy_o
);

    if (MODE == MODE_BYPASS) begin : g_bypass
        assign s_if.valid = m_if.valid;
        assign s_if.data  = m_if.data;
        assign m_if.ready = s_if.ready;
        assign busy_o     = 1'b0;

    end else if (MODE == MODE_FWD || MODE == MODE_BWD || MODE == MODE_FULL) begin : g_chain
        logic [STAGES-1:0] occ;

        // Each block owns the link into its stage; neighbours are only read, never driven
        for (genvar k = 0; k < STAGES; k++) begin : g_st
            logic             in_valid, in_ready, out_valid, out_ready;
            logic [WIDTH-1:0] in_data, out_data;

            hs_reg_slice_stage #(
                .WIDTH (WIDTH),
                .MODE  (MODE)
            ) u_stage (
                .clk         (clk),
                .rst         (rst),
                .in_valid_i  (in_valid),
                .in_ready_o  (in_ready),
                .in_data_i   (in_data),
                .out_valid_o (out_valid),
                .out_ready_i (out_ready),
                .out_data_o  (out_data),
                .occ_o       (occ[k])
            );

            if (k == 0) begin : g_head
                assign in_valid   = m_if.valid;
                assign in_data    = m_if.data;
                assign m_if.ready = in_ready;
            end else begin : g_link
                assign in_valid = g_st[k-1].out_valid;
                assign in_data  = g_st[k-1].out_data;
            end

            if (k == STAGES - 1) begin : g_tail
                assign s_if.valid = out_valid;
                assign s_if.data  = out_data;
                assign out_ready  = s_if.ready;
            end else begin : g_next
                assign out_ready = g_st[k+1].in_ready;
            end
        end

        assign busy_o = |occ;

    end else begin : g_bad
        $error("hs_reg_slice: illegal MODE %0d", MODE);
    end

endmodule

// File: tb/tb_hs_reg_slice.sv
// Scoreboard bench for hs_reg_slice: one DUT per MODE, scenario tasks run in sequence.
module tb_hs_reg_slice;
    import hs_pkg::*;

    localparam int unsigned NDUT = 4;
    localparam int          NRAND = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NDUT-1:0]       mv = '0, sr = '0;
    logic [NDUT-1:0][7:0]  md = '0;
    logic [NDUT-1:0]       mr, sv, bz;
    logic [NDUT-1:0][7:0]  sd;

    int errors = 0;
    int checks = 0;
    logic [7:0] sb[$];

    // DUT g runs MODE g; the FULL instance is three stages deep
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        hs_reg_slice_if #(.WIDTH(8)) up ();
        hs_reg_slice_if #(.WIDTH(8)) dn ();

        assign up.valid = mv[g];
        assign up.data  = md[g];
        assign mr[g]    = up.ready;
        assign sv[g]    = dn.valid;
        assign sd[g]    = dn.data;
        assign dn.ready = sr[g];

        hs_reg_slice #(
            .WIDTH  (8),
            .STAGES ((g == 3) ? 3 : 1),
            .MODE   (g)
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .m_if   (up),
            .s_if   (dn),
            .busy_o (bz[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mv  = '1;
        md  = {NDUT{8'hAA}};
        sr  = '1;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int d = 1; d < NDUT; d++) begin
                checks++;
                if (sv[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_s_valid dut%0d: got %b want 0", d, sv[d]);
                end
                checks++;
                if (bz[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_busy dut%0d: got %b want 0", d, bz[d]);
                end
                if (d != 2) begin
                    checks++;
                    if (sd[d] !== 8'h00) begin
                        errors++;
                        $display("FAIL reset_s_data dut%0d: got %h want 00", d, sd[d]);
                    end
                end
                if (d >= 2) begin
                    checks++;
                    if (mr[d] !== 1'b0) begin
                        errors++;
                        $display("FAIL reset_m_ready dut%0d: got %b want 0", d, mr[d]);
                    end
                end
            end
        end
        rst = 1'b0;
        mv  = '0;
        tick();
        for (int d = 1; d < NDUT; d++) begin
            checks++;
            if (mr[d] !== 1'b1) begin
                errors++;
                $display("FAIL release_m_ready dut%0d: got %b want 1", d, mr[d]);
            end
        end
    endtask

    task automatic test_fwd();
        logic [7:0] exp;
        sb.delete();
        sr[1] = 1'b1;
        for (int c = 0; c < 11; c++) begin
            tick();
            mv[1] = (c < 8);
            md[1] = 8'(c + 1);
            #1;
            checks++;
            if (sv[1] !== ((c >= 1) && (c <= 8))) begin
                errors++;
                $display("FAIL fwd_valid cycle%0d: got %b want %b", c, sv[1], (c >= 1) && (c <= 8));
            end
            if (mv[1] & mr[1]) sb.push_back(md[1]);
            if (sv[1] & sr[1]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL fwd_extra cycle%0d: got %h want nothing", c, sd[1]);
                end else begin
                    exp = sb.pop_front();
                    if (sd[1] !== exp) begin
                        errors++;
                        $display("FAIL fwd_data cycle%0d: got %h want %h", c, sd[1], exp);
                    end
                end
            end
        end
        mv[1] = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL fwd_lost: got %0d undelivered want 0", sb.size());
        end
    endtask

    task automatic test_bwd();
        logic [7:0] exp;
        int nxt = 1, got = 0, stall = 0;
        sb.delete();
        for (int c = 0; c < 16; c++) begin
            tick();
            sr[2] = (c != 2);
            mv[2] = (nxt <= 8);
            md[2] = 8'(nxt);
            #1;
            if (mv[2] & ~mr[2]) stall++;
            if (mv[2] & mr[2]) begin
                sb.push_back(md[2]);
                nxt++;
            end
            if (sv[2] & sr[2]) begin
                got++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL bwd_extra cycle%0d: got %h want nothing", c, sd[2]);
                end else begin
                    exp = sb.pop_front();
                    if (sd[2] !== exp) begin
                        errors++;
                        $display("FAIL bwd_data cycle%0d: got %h want %h", c, sd[2], exp);
                    end
                end
            end
        end
        mv[2] = 1'b0;
        sr[2] = 1'b0;
        checks++;
        if (stall != 1) begin
            errors++;
            $display("FAIL bwd_stall_cycles: got %0d want 1", stall);
        end
        checks++;
        if (got != 8) begin
            errors++;
            $display("FAIL bwd_count: got %0d want 8", got);
        end
    endtask

    task automatic test_full();
        logic [7:0] exp;
        int nxt = 1, acc = 0;
        sb.delete();
        sr[3] = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            mv[3] = (nxt <= 10);
            md[3] = 8'(nxt);
            #1;
            if (mv[3] & mr[3]) begin
                sb.push_back(md[3]);
                nxt++;
                acc++;
            end
        end
        checks++;
        if (acc != 6) begin
            errors++;
            $display("FAIL full_capacity: got %0d want 6", acc);
        end
        checks++;
        if (mr[3] !== 1'b0) begin
            errors++;
            $display("FAIL full_m_ready: got %b want 0", mr[3]);
        end
        checks++;
        if (bz[3] !== 1'b1) begin
            errors++;
            $display("FAIL full_busy_filled: got %b want 1", bz[3]);
        end
        mv[3] = 1'b0;
        sr[3] = 1'b1;
        #1;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) tick();
            checks++;
            if (sv[3] !== (c < 6)) begin
                errors++;
                $display("FAIL full_drain_valid cycle%0d: got %b want %b", c, sv[3], c < 6);
            end
            checks++;
            if (bz[3] !== (c < 6)) begin
                errors++;
                $display("FAIL full_drain_busy cycle%0d: got %b want %b", c, bz[3], c < 6);
            end
            if (sv[3] & sr[3]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL full_extra cycle%0d: got %h want nothing", c, sd[3]);
                end else begin
                    exp = sb.pop_front();
                    if (sd[3] !== exp) begin
                        errors++;
                        $display("FAIL full_data cycle%0d: got %h want %h", c, sd[3], exp);
                    end
                end
            end
        end
        sr[3] = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp;
        int got = 0;
        logic done = 1'b0;
        sb.delete();
        sr[3] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            mv[3] = 1'b1;
            md[3] = 8'(c + 1);
            #1;
            if (mv[3] & mr[3]) sb.push_back(md[3]);
        end
        tick();
        checks++;
        if (sb.size() != 4) begin
            errors++;
            $display("FAIL mid_buffered: got %0d want 4", sb.size());
        end
        rst   = 1'b1;
        md[3] = 8'h77;
        tick();
        checks++;
        if (sv[3] !== 1'b0) begin
            errors++;
            $display("FAIL mid_s_valid: got %b want 0", sv[3]);
        end
        checks++;
        if (bz[3] !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy: got %b want 0", bz[3]);
        end
        rst = 1'b0;
        sb.delete();
        md[3] = 8'h55;
        sr[3] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done) mv[3] = 1'b0;
            #1;
            if (mv[3] & mr[3]) begin
                sb.push_back(md[3]);
                done = 1'b1;
            end
            if (sv[3] & sr[3]) begin
                got++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL mid_stale cycle%0d: got %h want nothing", c, sd[3]);
                end else begin
                    exp = sb.pop_front();
                    if (sd[3] !== exp) begin
                        errors++;
                        $display("FAIL mid_data cycle%0d: got %h want %h", c, sd[3], exp);
                    end
                end
            end
        end
        mv[3] = 1'b0;
        sr[3] = 1'b0;
        checks++;
        if (got != 1) begin
            errors++;
            $display("FAIL mid_count: got %0d want 1", got);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp, prev_sd;
        logic       pend, hold_prev, mr_a;
        int         pushed, popped, cyc;
        for (int d = 0; d < int'(NDUT); d++) begin
            rst = 1'b1;
            mv  = '0;
            sr  = '0;
            tick();
            rst = 1'b0;
            sb.delete();
            pushed = 0;
            popped = 0;
            cyc = 0;
            pend = 1'b0;
            hold_prev = 1'b0;
            prev_sd = '0;
            while ((pushed < NRAND || sb.size() != 0) && cyc < 20000) begin
                tick();
                cyc++;
                if (hold_prev) begin
                    checks++;
                    if (sv[d] !== 1'b1 || sd[d] !== prev_sd) begin
                        errors++;
                        $display("FAIL rand_hold dut%0d cycle%0d: got v=%b d=%h want v=1 d=%h",
                                 d, cyc, sv[d], sd[d], prev_sd);
                    end
                end
                sr[d] = 1'($urandom_range(0, 1));
                if (!pend) begin
                    mv[d] = (pushed < NRAND) ? 1'($urandom_range(0, 1)) : 1'b0;
                    md[d] = 8'($urandom);
                end
                #1;
                if (d >= 2) begin
                    mr_a  = mr[d];
                    sr[d] = ~sr[d];
                    #1;
                    checks++;
                    if (mr[d] !== mr_a) begin
                        errors++;
                        $display("FAIL rand_ready_path dut%0d cycle%0d: got %b want %b", d, cyc, mr[d], mr_a);
                    end
                    sr[d] = ~sr[d];
                    #1;
                end
                if (mv[d] & mr[d]) begin
                    sb.push_back(md[d]);
                    pushed++;
                    pend = 1'b0;
                end else begin
                    pend = mv[d];
                end
                if (sv[d] & sr[d]) begin
                    popped++;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL rand_extra dut%0d cycle%0d: got %h want nothing", d, cyc, sd[d]);
                    end else begin
                        exp = sb.pop_front();
                        if (sd[d] !== exp) begin
                            errors++;
                            $display("FAIL rand_data dut%0d cycle%0d: got %h want %h", d, cyc, sd[d], exp);
                        end
                    end
                end
                hold_prev = sv[d] & ~sr[d];
                prev_sd   = sd[d];
            end
            mv = '0;
            sr = '0;
            checks++;
            if (cyc >= 20000) begin
                errors++;
                $display("FAIL rand_timeout dut%0d: got %0d cycles want <20000", d, cyc);
            end
            checks++;
            if (popped != NRAND) begin
                errors++;
                $display("FAIL rand_count dut%0d: got %0d want %0d", d, popped, NRAND);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fwd();
        test_bwd();
        test_full();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
